seg7_mux_n: RTL and testbench

SEG7_MUX_N -- requirements
Module: seg7_mux_n

---
 rtl/seg7_pkg.sv | 53 +++++
 rtl/seg7_hexdec.sv | 20 ++
 rtl/seg7_mux_n.sv | 218 +++++++++++++++++++++
 tb/tb_seg7_mux_n.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg -- shared constants for the multiplexed seven-segment driver.
//
// Contents:
//   SEG_A..SEG_G, SEG_DP : one-hot bit masks for the segment byte
//                          (a..g = bits 0..6, decimal point = bit 7).
//   HEX_TABLE            : 16-entry active-high segment pattern per hex digit
//                          (0-9, A, b, c, d, E, F).
//   disp_mode_e          : display mode captured in the frame snapshot.
//   hex_pattern()        : table lookup helper used by seg7_hexdec.
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [7:0] SEG_A  = 8'h01;
    localparam logic [7:0] SEG_B  = 8'h02;
    localparam logic [7:0] SEG_C  = 8'h04;
    localparam logic [7:0] SEG_D  = 8'h08;
    localparam logic [7:0] SEG_E  = 8'h10;
    localparam logic [7:0] SEG_F  = 8'h20;
    localparam logic [7:0] SEG_G  = 8'h40;
    localparam logic [7:0] SEG_DP = 8'h80;

    // Packed so that HEX_TABLE[n] is the pattern for nibble n; the leftmost
    // entry of the concatenation is index 15.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'(SEG_A | SEG_E | SEG_F | SEG_G),                          // F
        7'(SEG_A | SEG_D | SEG_E | SEG_F | SEG_G),                  // E
        7'(SEG_B | SEG_C | SEG_D | SEG_E | SEG_G),                  // d
        7'(SEG_D | SEG_E | SEG_G),                                  // c (lower case)
        7'(SEG_C | SEG_D | SEG_E | SEG_F | SEG_G),                  // b
        7'(SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G),          // A
        7'(SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G),          // 9
        7'(SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G),  // 8
        7'(SEG_A | SEG_B | SEG_C),                                  // 7
        7'(SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G),          // 6
        7'(SEG_A | SEG_C | SEG_D | SEG_F | SEG_G),                  // 5
        7'(SEG_B | SEG_C | SEG_F | SEG_G),                          // 4
        7'(SEG_A | SEG_B | SEG_C | SEG_D | SEG_G),                  // 3
        7'(SEG_A | SEG_B | SEG_D | SEG_E | SEG_G),                  // 2
        7'(SEG_B | SEG_C),                                          // 1
        7'(SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F)           // 0
    };

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_RAW = 1'b1
    } disp_mode_e;

    function automatic logic [6:0] hex_pattern(input logic [3:0] nibble);
        return HEX_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hexdec.sv
// ---------------------------------------------------------------------------
// seg7_hexdec -- combinational hex nibble to seven-segment decoder.
//
// Ports:
//   nibble_i [3:0] : hex digit to display
//   seg_o    [6:0] : active-high segment pattern, a..g = bits 0..6
// ---------------------------------------------------------------------------
module seg7_hexdec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Pure table lookup; polarity is applied by the caller.
    always_comb begin
        seg_o = hex_pattern(nibble_i);
    end

endmodule

// File: rtl/seg7_mux_n.sv
// ---------------------------------------------------------------------------
// seg7_mux_n -- time-multiplexed driver for DIGITS seven-segment digits.
//
// Each digit owns a slot of 2^PRE clocks. Inputs are captured once per frame
// (on the tick that wraps the digit index back to 0) so a whole frame shows
// one coherent value set. The first clock of every slot is dark to stop the
// previous digit ghosting onto the next anode. Outputs are registered.
//
// Parameters:
//   DIGITS     : number of digits (2..16)
//   PRE        : slot length is 2^PRE clocks (4..24)
//   ACTIVE_LOW : 1 = seg/an low-active, 0 = high-active
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   di           : hex nibble per digit, digit i = di[4i+3:4i]
//   dp           : decimal point per digit (hex mode)
//   blank        : 1 = digit dark (hex mode)
//   pixels       : raw segment bytes, digit 0 is the most significant byte
//   direct       : 1 = raw pixel mode, 0 = hex mode
//   bright [3:0] : brightness, present only with SEG7_DIM_EN defined
//   seg    [7:0] : segments a..g = bits 0..6, dp = bit 7
//   an           : one anode per digit
//   frame        : one-clock pulse at the start of every frame
//
// Build option: define SEG7_DIM_EN to add the bright input (PWM dimming of
// the anode within each slot, sampled with the frame snapshot).
// ---------------------------------------------------------------------------
module seg7_mux_n
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int PRE        = 14,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   di,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [8*DIGITS-1:0]   pixels,
    input  logic                  direct,
`ifdef SEG7_DIM_EN
    input  logic [3:0]            bright,
`endif
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int                CW         = $clog2(DIGITS);
    localparam logic [PRE-1:0]    PRE_MAX    = {PRE{1'b1}};
    localparam logic [PRE-1:0]    PRE_ZERO   = {PRE{1'b0}};
    localparam logic [CW-1:0]     LAST_DIGIT = CW'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF    = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF     = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                 : {DIGITS{1'b0}};

    // Scan counters
    logic [PRE-1:0]    pre_cnt_q, pre_cnt_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick_s;
    logic              wrap_s;

    // Frame snapshot
    logic [4*DIGITS-1:0] di_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   blank_q;
    logic [8*DIGITS-1:0] pixels_q;
    disp_mode_e          mode_q;
`ifdef SEG7_DIM_EN
    logic [3:0]          bright_q;
`endif

    // Display datapath
    logic [3:0]          nib_arr_s [DIGITS];
    logic [7:0]          pix_arr_s [DIGITS];
    logic [DIGITS-1:0]   an_hot_s;
    logic [3:0]          nib_sel_s;
    logic [6:0]          hex_pat_s;
    logic                dim_on_s;
    logic [7:0]          seg_raw_s;
    logic [DIGITS-1:0]   an_raw_s;
    logic                lit_s;
    logic                dead_s;

    logic                frame_q;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    assign tick_s = (pre_cnt_q == PRE_MAX);
    assign wrap_s = tick_s && (cnt_q == LAST_DIGIT);
    assign dead_s = (pre_cnt_q == PRE_ZERO);

    // Next-state for the prescaler and the digit index.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE'(1'b1);
        if (tick_s) begin
            if (cnt_q == LAST_DIGIT) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Scan counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q <= PRE_ZERO;
            cnt_q     <= {CW{1'b0}};
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    // Capture all display inputs once per frame, on the wrap tick only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            di_q     <= {(4*DIGITS){1'b0}};
            dp_q     <= {DIGITS{1'b0}};
            blank_q  <= {DIGITS{1'b0}};
            pixels_q <= {(8*DIGITS){1'b0}};
            mode_q   <= MODE_HEX;
`ifdef SEG7_DIM_EN
            bright_q <= 4'd0;
`endif
        end else if (wrap_s) begin
            di_q     <= di;
            dp_q     <= dp;
            blank_q  <= blank;
            pixels_q <= pixels;
            mode_q   <= disp_mode_e'(direct);
`ifdef SEG7_DIM_EN
            bright_q <= bright;
`endif
        end
    end

    // Per-digit views of the snapshot; pixels are stored MSB-byte-first.
    for (genvar g = 0; g < DIGITS; g++) begin : g_lane
        assign nib_arr_s[g] = di_q[4*g +: 4];
        assign pix_arr_s[g] = pixels_q[8*(DIGITS-1-g) +: 8];
        assign an_hot_s[g]  = (cnt_q == CW'(g));
    end

    assign nib_sel_s = nib_arr_s[cnt_q];

    seg7_hexdec u_hexdec (
        .nibble_i (nib_sel_s),
        .seg_o    (hex_pat_s)
    );

`ifdef SEG7_DIM_EN
    // Anode on while the top four prescaler bits are below bright+1.
    assign dim_on_s = ({1'b0, pre_cnt_q[PRE-1 -: 4]} < ({1'b0, bright_q} + 5'd1));
`else
    assign dim_on_s = 1'b1;
`endif

    // Select the segment byte for the current digit, then gate and polarise.
    always_comb begin
        seg_raw_s = 8'h00;
        lit_s     = 1'b0;
        if (mode_q == MODE_RAW) begin
            seg_raw_s = pix_arr_s[cnt_q];
            lit_s     = 1'b1;
        end else if (blank_q[cnt_q]) begin
            seg_raw_s = 8'h00;
            lit_s     = 1'b0;
        end else begin
            seg_raw_s = {1'b0, hex_pat_s} | (dp_q[cnt_q] ? SEG_DP : 8'h00);
            lit_s     = 1'b1;
        end

        if (dead_s) begin
            seg_raw_s = 8'h00;
        end else begin
            seg_raw_s = seg_raw_s;
        end

        if (lit_s && !dead_s && dim_on_s) begin
            an_raw_s = an_hot_s;
        end else begin
            an_raw_s = {DIGITS{1'b0}};
        end

        if (ACTIVE_LOW != 0) begin
            seg_d = ~seg_raw_s;
            an_d  = ~an_raw_s;
        end else begin
            seg_d = seg_raw_s;
            an_d  = an_raw_s;
        end
    end

    // Registered outputs; fully inactive while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= wrap_s;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_mux_n.sv
// ---------------------------------------------------------------------------
// tb_seg7_mux_n -- self-checking bench for seg7_mux_n (PRE=4, ACTIVE_LOW=1),
// with one 8-digit and one 5-digit instance sharing clock and stimulus.
// The reference model tracks elapsed clocks since reset release and derives
// slot, digit, frame and snapshot timing arithmetically.
// ---------------------------------------------------------------------------
module tb_seg7_mux_n;

    typedef struct packed {
        logic [31:0] di;
        logic [7:0]  dp;
        logic [7:0]  bl;
        logic [63:0] pix;
        logic        dir;
    } snap_t;

    localparam int SLOT = 16;
    localparam logic [6:0] HEXLUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] di;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [63:0] pixels;
    logic        direct;

    logic [7:0]  seg8;
    logic [7:0]  an8;
    logic        frame8;
    logic [7:0]  seg5;
    logic [4:0]  an5;
    logic        frame5;

    int          n_vec = 0;
    int          n_err = 0;
    logic        checking = 1'b0;

    snap_t       cur_s;
    snap_t       s8, s5;
    int          e8, e5;
    logic [15:0] x8, x5;
    logic        f8, f5;

    always #5 clk = ~clk;

    seg7_mux_n #(.DIGITS(8), .PRE(4), .ACTIVE_LOW(1)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .di     (di),
        .dp     (dp),
        .blank  (blank),
        .pixels (pixels),
        .direct (direct),
        .seg    (seg8),
        .an     (an8),
        .frame  (frame8)
    );

    seg7_mux_n #(.DIGITS(5), .PRE(4), .ACTIVE_LOW(1)) dut5 (
        .clk    (clk),
        .reset  (reset),
        .di     (di[19:0]),
        .dp     (dp[4:0]),
        .blank  (blank[4:0]),
        .pixels (pixels[39:0]),
        .direct (direct),
        .seg    (seg5),
        .an     (an5),
        .frame  (frame5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Expected {seg, an} for elapsed clock count e: slot = e/16, digit = slot mod D.
    function automatic logic [15:0] exp_calc(input int D, input int e, input snap_t s);
        int         pre;
        int         d;
        logic [7:0] seg_h;
        logic [7:0] an_h;
        logic [7:0] mask;
        pre  = e % SLOT;
        d    = (e / SLOT) % D;
        mask = 8'((1 << D) - 1);
        seg_h = 8'h00;
        an_h  = 8'h00;
        if (pre == 0) begin
            seg_h = 8'h00;
            an_h  = 8'h00;
        end else if (s.dir) begin
            seg_h = s.pix[8*(D-1-d) +: 8];
            an_h  = 8'(1 << d);
        end else if (s.bl[d]) begin
            seg_h = 8'h00;
            an_h  = 8'h00;
        end else begin
            seg_h = {s.dp[d], HEXLUT[s.di[4*d +: 4]]};
            an_h  = 8'(1 << d);
        end
        return {~seg_h, (~an_h) & mask};
    endfunction

    assign cur_s = {di, dp, blank, pixels, direct};

    // Reference model: one output step per clock, snapshot once per frame.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e8 <= 0;
            e5 <= 0;
            s8 <= '0;
            s5 <= '0;
            x8 <= 16'hFFFF;
            x5 <= 16'hFF1F;
            f8 <= 1'b0;
            f5 <= 1'b0;
        end else begin
            x8 <= exp_calc(8, e8, s8);
            f8 <= (((e8 + 1) % (8 * SLOT)) == 0);
            if (((e8 + 1) % (8 * SLOT)) == 0) s8 <= cur_s;
            e8 <= e8 + 1;
            x5 <= exp_calc(5, e5, s5);
            f5 <= (((e5 + 1) % (5 * SLOT)) == 0);
            if (((e5 + 1) % (5 * SLOT)) == 0) s5 <= cur_s;
            e5 <= e5 + 1;
        end
    end

    // Compare every output on the falling edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("seg8",   {24'h0, seg8},   {24'h0, x8[15:8]});
            chk("an8",    {24'h0, an8},    {24'h0, x8[7:0]});
            chk("frame8", {31'h0, frame8}, {31'h0, f8});
            chk("seg5",   {24'h0, seg5},   {24'h0, x5[15:8]});
            chk("an5",    {27'h0, an5},    {24'h0, x5[7:0]});
            chk("frame5", {31'h0, frame5}, {31'h0, f5});
        end
    end

    task automatic rand_inputs();
        di     = $urandom;
        dp     = 8'($urandom);
        blank  = 8'($urandom_range(0, 255)) & 8'($urandom);
        pixels = {$urandom, $urandom};
        direct = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        reset  = 1'b1;
        di     = 32'h0;
        dp     = 8'h00;
        blank  = 8'h00;
        pixels = 64'h0;
        direct = 1'b0;
        repeat (3) @(posedge clk);
        #1 checking = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;

        // Hex digits 0..7, one per position.
        di = 32'h7654_3210;
        repeat (384) @(negedge clk);

        // Mid-frame change must not tear the current frame.
        di = 32'h0;
        repeat (200) @(negedge clk);
        di = 32'hFFFF_FFFF;
        repeat (300) @(negedge clk);

        // Raw pixel mode: blank and dp are ignored.
        direct = 1'b1;
        blank  = 8'hFF;
        dp     = 8'hFF;
        pixels = {8'h3F, 24'($urandom), $urandom};
        repeat (260) @(negedge clk);

        // Hex mode with one blanked digit and one decimal point.
        direct = 1'b0;
        blank  = 8'h02;
        dp     = 8'h01;
        di     = $urandom;
        repeat (260) @(negedge clk);

        // Randomised inputs changing at random points in the frame.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(1, 90)) @(negedge clk);
            rand_inputs();
        end
        repeat (150) @(negedge clk);

        // Reset mid-slot: outputs go inactive in the same cycle.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_seg8", {24'h0, seg8}, 32'h0000_00FF);
        chk("rst_an8",  {24'h0, an8},  32'h0000_00FF);
        chk("rst_seg5", {24'h0, seg5}, 32'h0000_00FF);
        chk("rst_an5",  {27'h0, an5},  32'h0000_001F);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        di     = 32'h7654_3210;
        direct = 1'b0;
        blank  = 8'h00;
        dp     = 8'h00;
        repeat (400) @(negedge clk);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
